// File: rtl/serial_sub.sv
// Bit-serial unsigned subtractor: one full-subtractor cell, LSB first, W clocks per operation.
// Build option: define SERIAL_SUB_SAT_EN to clamp the result to zero when the final borrow is set.
module serial_sub #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         ready,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] diff,
  output logic         bout
);

  localparam int CW = $clog2(W) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state_reg;
  logic [W-1:0]   a_sh_reg;
  logic [W-1:0]   b_sh_reg;
  logic [W-1:0]   res_reg;
  logic [CW-1:0]  cnt_reg;
  logic           borrow_reg;

  logic           x, y, d, borrow_next, last_bit;
  logic [W-1:0]   res_next;

  // Full-subtractor cell on the current LSBs and the carried borrow.
  assign x           = a_sh_reg[0];
  assign y           = b_sh_reg[0];
  assign d           = x ^ y ^ borrow_reg;
  assign borrow_next = (~x & y) | (~(x ^ y) & borrow_reg);
  assign res_next    = {d, res_reg[W-1:1]};
  assign last_bit    = (cnt_reg == CW'(W - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      a_sh_reg   <= '0;
      b_sh_reg   <= '0;
      res_reg    <= '0;
      cnt_reg    <= '0;
      borrow_reg <= 1'b0;
      ready      <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      diff       <= '0;
      bout       <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_sh_reg   <= a;
            b_sh_reg   <= b;
            res_reg    <= '0;
            cnt_reg    <= '0;
            borrow_reg <= 1'b0;
            state_reg  <= RUN;
            ready      <= 1'b0;
            busy       <= 1'b1;
          end else begin
            state_reg  <= IDLE;
            ready      <= 1'b1;
            busy       <= 1'b0;
          end
        end
        RUN: begin
          a_sh_reg   <= a_sh_reg >> 1;
          b_sh_reg   <= b_sh_reg >> 1;
          res_reg    <= res_next;
          borrow_reg <= borrow_next;
          cnt_reg    <= cnt_reg + 1'b1;
          if (last_bit) begin
            state_reg <= DONE;
            busy      <= 1'b0;
            ready     <= 1'b1;
            done      <= 1'b1;
            bout      <= borrow_next;
`ifdef SERIAL_SUB_SAT_EN
            diff      <= borrow_next ? '0 : res_next;
`else
            diff      <= res_next;
`endif
          end
        end
        default: begin
          state_reg <= IDLE;
          ready     <= 1'b1;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule
